// File: rtl/payload_match_chain.sv
// Configurable single-pattern match chain: one state cell per pattern position,
// plus a first-match offset capture and a saturating match counter.

module pmc_state_cell #(
  parameter int               NUM_CLASSES = 48,
  parameter int               CLS_W       = 6,
  parameter logic [CLS_W-1:0] SEL         = '0,
  parameter bit               LOOP        = 1'b0
) (
  input  logic                   clk,
  input  logic                   sod,
  input  logic                   en,
  input  logic [NUM_CLASSES-1:0] in_class,
  input  logic                   prev,
  output logic                   nxt,
  output logic                   state
);
  // An out-of-range class index yields an empty mask, so the state never activates.
  localparam logic [NUM_CLASSES-1:0] SEL_MASK =
    (int'(SEL) < NUM_CLASSES) ? (NUM_CLASSES'(1) << SEL) : '0;

  logic hit;
  assign hit = |(in_class & SEL_MASK);
  assign nxt = hit & (prev | (LOOP & state));

  always_ff @(posedge clk or posedge sod) begin
    if (sod)     state <= 1'b0;
    else if (en) state <= nxt;
  end
endmodule

module payload_match_chain #(
  parameter int                          NUM_STATES  = 15,
  parameter int                          NUM_CLASSES = 48,
  parameter int                          CLS_W       = 6,
  parameter logic [NUM_STATES*CLS_W-1:0] CLASS_SEL   = {6'd35, 6'd7, 6'd6, 6'd12, 6'd13,
                                                        6'd25, 6'd8, 6'd19, 6'd15, 6'd4,
                                                        6'd5, 6'd21, 6'd29, 6'd25, 6'd46},
  parameter logic [NUM_STATES-1:0]       LOOP_MASK   = 15'b000_0100_0000_0000,
  parameter int                          ANCHORED    = 0,
  parameter int                          OFS_W       = 16,
  parameter int                          CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   sod,
  input  logic                   en,
  input  logic [NUM_CLASSES-1:0] in_class,
  output logic                   match,
  output logic                   match_pulse,
  output logic [OFS_W-1:0]       match_offset,
  output logic [CNT_W-1:0]       match_count,
  output logic [NUM_STATES-1:0]  state_vec
);
  logic                  first;
  logic [OFS_W-1:0]      ofs;
  logic                  seed;
  logic                  done;
  logic [NUM_STATES-1:0] chain_in;
  logic [NUM_STATES-1:0] next_state;

  assign seed = (ANCHORED != 0) ? first : 1'b1;

  genvar i;
  generate
    for (i = 0; i < NUM_STATES; i++) begin : g_st
      if (i == 0) begin : g_head
        assign chain_in[i] = seed;
      end else begin : g_body
        assign chain_in[i] = state_vec[i-1];
      end
      pmc_state_cell #(
        .NUM_CLASSES (NUM_CLASSES),
        .CLS_W       (CLS_W),
        .SEL         (CLASS_SEL[i*CLS_W +: CLS_W]),
        .LOOP        (LOOP_MASK[i])
      ) u_cell (
        .clk      (clk),
        .sod      (sod),
        .en       (en),
        .in_class (in_class),
        .prev     (chain_in[i]),
        .nxt      (next_state[i]),
        .state    (state_vec[i])
      );
    end
  endgenerate

  // Completion is taken from the next-state value so match lands on the same edge.
  assign done = en & next_state[NUM_STATES-1];

  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      first        <= 1'b1;
      ofs          <= '0;
      match        <= 1'b0;
      match_pulse  <= 1'b0;
      match_offset <= '0;
      match_count  <= '0;
    end else begin
      match_pulse <= done & ~match;
      if (en) begin
        first <= 1'b0;
        if (ofs != '1) ofs <= ofs + 1'b1;
      end
      if (done) begin
        if (!match) begin
          match        <= 1'b1;
          match_offset <= ofs;
        end
        if (match_count != '1) match_count <= match_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_payload_match_chain.sv
// Directed bench: a vector table of byte strings against several parameterisations,
// plus hand-written sequences for gaps, saturation and asynchronous sod.

module tb_payload_match_chain;
  logic        clk = 1'b0;
  logic        sod;
  logic        en;
  logic [47:0] in_class;

  logic        m0, p0, mA, pA, mU, pU, m1, p1, m2, p2;
  logic [15:0] o0, oA, oU, o1, o2;
  logic [7:0]  c0, cA, cU, c1, c2;
  logic [14:0] s0;
  logic [13:0] sA, sU;
  logic [0:0]  s1, s2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  payload_match_chain u_dut (
    .clk(clk), .sod(sod), .en(en), .in_class(in_class),
    .match(m0), .match_pulse(p0), .match_offset(o0), .match_count(c0), .state_vec(s0));

  payload_match_chain #(
    .NUM_STATES(14),
    .CLASS_SEL({6'd35, 6'd7, 6'd6, 6'd12, 6'd13, 6'd25, 6'd8,
                6'd19, 6'd15, 6'd4, 6'd5, 6'd21, 6'd29, 6'd25}),
    .LOOP_MASK(14'b00_0010_0000_0000), .ANCHORED(1)
  ) u_anch (
    .clk(clk), .sod(sod), .en(en), .in_class(in_class),
    .match(mA), .match_pulse(pA), .match_offset(oA), .match_count(cA), .state_vec(sA));

  payload_match_chain #(
    .NUM_STATES(14),
    .CLASS_SEL({6'd35, 6'd7, 6'd6, 6'd12, 6'd13, 6'd25, 6'd8,
                6'd19, 6'd15, 6'd4, 6'd5, 6'd21, 6'd29, 6'd25}),
    .LOOP_MASK(14'b00_0010_0000_0000), .ANCHORED(0)
  ) u_unanch (
    .clk(clk), .sod(sod), .en(en), .in_class(in_class),
    .match(mU), .match_pulse(pU), .match_offset(oU), .match_count(cU), .state_vec(sU));

  payload_match_chain #(.NUM_STATES(1), .CLASS_SEL(6'd47), .LOOP_MASK(1'b0)) u_one (
    .clk(clk), .sod(sod), .en(en), .in_class(in_class),
    .match(m1), .match_pulse(p1), .match_offset(o1), .match_count(c1), .state_vec(s1));

  // Class index past NUM_CLASSES: must never activate.
  payload_match_chain #(.NUM_STATES(1), .CLASS_SEL(6'd50), .LOOP_MASK(1'b0)) u_oor (
    .clk(clk), .sod(sod), .en(en), .in_class(in_class),
    .match(m2), .match_pulse(p2), .match_offset(o2), .match_count(c2), .state_vec(s2));

  typedef struct {
    string text;
    int    dut;     // 0 default, 1 anchored N=14, 2 unanchored N=14
    bit    exp_m;
    int    exp_ofs;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[7];

  function automatic int cls(input byte c);
    case (c)
      "^": return 46;  "/": return 25;  "u": return 29;  "p": return 21;
      "l": return 5;   "o": return 4;   "a": return 15;  "d": return 19;
      "s": return 8;   ".": return 12;  "g": return 6;   "i": return 7;
      "f": return 35;
      default: return (c >= "0" && c <= "9") ? 13 : 40;
    endcase
  endfunction

  function automatic logic [47:0] onehot(input int k);
    logic [47:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int d, output bit m, output bit p, output longint o,
                        output longint c, output longint s);
    case (d)
      1:       begin m = mA; p = pA; o = oA; c = cA; s = sA; end
      2:       begin m = mU; p = pU; o = oU; c = cU; s = sU; end
      default: begin m = m0; p = p0; o = o0; c = c0; s = s0; end
    endcase
  endtask

  task automatic do_sod();
    en = 1'b0;
    in_class = '0;
    sod = 1'b1;
    @(posedge clk);
    #1 sod = 1'b0;
  endtask

  task automatic send(input byte c, input bit e);
    en = e;
    in_class = onehot(cls(c));
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k);
    bit m, p;
    longint o, c, s;
    int pulses, rise;
    pulses = 0;
    rise = -1;
    do_sod();
    for (int i = 0; i < vecs[k].text.len(); i++) begin
      send(vecs[k].text[i], 1'b1);
      sample(vecs[k].dut, m, p, o, c, s);
      if (p) pulses++;
      if (m && rise < 0) rise = i;
    end
    for (int i = 0; i < 3; i++) begin
      send("x", 1'b0);
      sample(vecs[k].dut, m, p, o, c, s);
      if (p) pulses++;
    end
    chk($sformatf("v%0d match", k), m, vecs[k].exp_m);
    chk($sformatf("v%0d pulses", k), pulses, vecs[k].exp_m);
    chk($sformatf("v%0d offset", k), o, vecs[k].exp_ofs);
    chk($sformatf("v%0d count", k), c, vecs[k].exp_cnt);
    if (vecs[k].exp_m) chk($sformatf("v%0d rise_byte", k), rise, vecs[k].exp_ofs);
  endtask

  initial begin
    bit m, p;
    longint o, c, s, held;
    int pulses, gap;

    vecs[0] = '{"^/uploads/123.gif",              0, 1'b1, 16, 1};
    vecs[1] = '{"^/uploads/.gif",                 0, 1'b0, 0,  0};
    vecs[2] = '{"^/uploads/9999999.gif",          0, 1'b1, 20, 1};
    vecs[3] = '{"/uploads/7.gif",                 1, 1'b1, 13, 1};
    vecs[4] = '{"xyz/uploads/7.gif",              1, 1'b0, 0,  0};
    vecs[5] = '{"xyz/uploads/7.gif",              2, 1'b1, 16, 1};
    vecs[6] = '{"^/uploads/1.gif^/uploads/22.gif", 0, 1'b1, 14, 2};

    sod = 1'b1;
    en = 1'b0;
    in_class = '0;
    #2;
    chk("reset match", m0, 0);
    chk("reset pulse", p0, 0);
    chk("reset offset", o0, 0);
    chk("reset count", c0, 0);
    chk("reset state_vec", s0, 0);
    @(posedge clk);
    #1 sod = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(k);

    // Enable gaps: next byte's classes are presented during the gap but must be ignored.
    do_sod();
    pulses = 0;
    for (int i = 0; i < vecs[0].text.len(); i++) begin
      gap = $urandom_range(0, 2);
      held = s0;
      for (int g = 0; g < gap; g++) begin
        send(vecs[0].text[i], 1'b0);
        chk($sformatf("gap hold b%0d", i), s0, held);
        if (p0) pulses++;
      end
      send(vecs[0].text[i], 1'b1);
      if (p0) pulses++;
    end
    send("x", 1'b0);
    if (p0) pulses++;
    chk("gap match", m0, 1);
    chk("gap offset", o0, 16);
    chk("gap pulses", pulses, 1);

    // Saturation: final state active on all 300 bytes.
    do_sod();
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      en = 1'b1;
      in_class = '1;
      @(posedge clk);
      #1;
      if (p1) pulses++;
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    if (p1) pulses++;
    chk("sat match", m1, 1);
    chk("sat offset", o1, 0);
    chk("sat pulses", pulses, 1);
    chk("sat count", c1, 255);
    chk("oor match", m2, 0);
    chk("oor state_vec", s2, 0);
    chk("oor count", c2, 0);

    // Asynchronous sod after byte 12 of a second copy of the string.
    do_sod();
    for (int i = 0; i < vecs[0].text.len(); i++) send(vecs[0].text[i], 1'b1);
    for (int i = 0; i < 13; i++) send(vecs[0].text[i], 1'b1);
    chk("pre-sod state_vec", s0, 15'h0400);
    chk("pre-sod count", c0, 1);
    chk("pre-sod match", m0, 1);
    #3 sod = 1'b1;
    #1;
    chk("async state_vec", s0, 0);
    chk("async match", m0, 0);
    chk("async count", c0, 0);
    chk("async offset", o0, 0);
    @(posedge clk);
    #1 sod = 1'b0;
    for (int i = 0; i < vecs[0].text.len(); i++) send(vecs[0].text[i], 1'b1);
    send("x", 1'b0);
    chk("resend match", m0, 1);
    chk("resend offset", o0, 16);
    chk("resend count", c0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/payload_match_chain.md
# payload_match_chain

Parametrised, configurable single-pattern match chain for the payload engine. It replaces the fixed per-rule state chains: pattern length, per-state character class, self-loop (`+`) positions and anchoring are set by parameters. It adds a first-match byte offset and a saturating match counter. Each instance sits between the shared character-class decoder, which supplies the `in_class` vector, and the rule aggregation logic, which consumes `match`.

## Interface
- `NUM_STATES`, 15: number of chain states (1..64).
- `NUM_CLASSES`, 48: width of the class-hit vector (≤64).
- `CLS_W`, 6: bits per class index.
- `CLASS_SEL`, {46,25,29,21,5,4,15,19,8,25,13,12,6,7,35}: packed `NUM_STATES*CLS_W`; field i is the class index of state i, with state 0 in the LSBs.
- `LOOP_MASK`, 15'b000_0100_0000_0000: bit i=1 lets state i self-loop (`+`).
- `ANCHORED`, 0: 1 = chain seeds only on the first enabled byte after `sod`; 0 = chain seeds on every enabled byte.
- `OFS_W`, 16: byte-offset width.
- `CNT_W`, 8: match-counter width.

Ports:
- `clk`, in, 1: clock.
- `sod`, in, 1: start of data. Reset is asynchronous and active-high; it clears all state.
- `en`, in, 1: byte valid. Only enabled cycles advance the chain.
- `in_class`, in, NUM_CLASSES: class hits for the current byte.
- `match`, out, 1: sticky match flag.
- `match_pulse`, out, 1: one-cycle pulse on the first match only.
- `match_offset`, out, OFS_W: index of the byte that completed the first match.
- `match_count`, out, CNT_W: number of enabled bytes on which the final state became active, saturating.
- `state_vec`, out, NUM_STATES: active-state register (debug).

## Operation
- `hit[i] = in_class[CLASS_SEL[i*CLS_W +: CLS_W]]`.
- `seed = ANCHORED ? first : 1`.
  - `first` is set by `sod` and cleared on the first enabled byte.
- On `en=1`:
  - State 0: `state[0] <= hit[0] & (seed | (LOOP_MASK[0] & state[0]))`.
  - States i>0: `state[i] <= hit[i] & (state[i-1] | (LOOP_MASK[i] & state[i]))`.
- On `en=0`: all registers hold.
- `done = en & next_state[NUM_STATES-1]`, where `next_state` is the combinational value computed above.
- Byte counter `ofs`:
  - Increments on each enabled byte.
  - Saturates at all-ones.
  - Is 0 for the first byte after `sod`.
- When `done`:
  - If `match=0`: `match<=1`, `match_pulse<=1`, `match_offset<=ofs` (pre-increment value).
  - In all cases: `match_count<=match_count+1`, saturating at `2^CNT_W-1`.
- `match_pulse` is cleared on every cycle in which it is not being set.
- `match` stays 1 until `sod`. Later matches update only `match_count`.
- `CLASS_SEL` field value ≥ NUM_CLASSES: that state never activates.
- `sod` asserted mid-packet: all outputs go to 0 immediately (asynchronous). Processing restarts with the next enabled byte after `sod` deasserts, which is byte 0.

## Timing
- Reset value of every output: `match=0`, `match_pulse=0`, `match_offset=0`, `match_count=0`, `state_vec=0`. Internal `first=1`, `ofs=0`.
- Latency: `match`, `match_pulse` and `match_offset` are valid after the rising edge that samples the completing byte with `en=1`, i.e. one cycle.
  - This is one cycle earlier than the previous end-state scheme.
  - `match` does not depend on a further `en`.
- `match_pulse` is high for exactly one `clk` cycle per `sod` interval.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `en` may toggle every cycle. Gaps do not break the chain.

## Test plan
- **Basic match.** Default params; bench drives class bits for "^/uploads/123.gif" as bytes 0..16 (byte 0 = class 46 only). Required:
  - `match` rises after the byte-16 edge.
  - `match_offset=16`, `match_pulse` high one cycle, `match_count=1`.
- **Loop boundaries.** "^/uploads/.gif" (zero digits): `match` stays 0. "^/uploads/9999999.gif": match with `match_offset=20`.
- **Anchoring.**
  - `ANCHORED=1`, `NUM_STATES=14`, class 46 dropped: "/uploads/7.gif" at byte 0 gives `match_offset=13`.
  - Same string starting at byte 3 gives no match.
  - With `ANCHORED=0`, byte 3 start matches at `match_offset=16`.
- **Enable gaps.** Basic-match stream with `en=0` inserted randomly between bytes: same `match_offset=16`, and `state_vec` holds during each gap.
- **Repeated matches and saturation.** `NUM_STATES=1`, `LOOP_MASK=0`, class hit on every one of 300 enabled bytes with `CNT_W=8`. Required:
  - `match_offset=0`.
  - `match_pulse` high once.
  - `match_count` saturates at 255.
- **Reset mid-packet.** `sod` pulsed mid-cycle after byte 12 of the basic-match stream: `state_vec`, `match` and `match_count` go to 0 before the next edge. Resending the full string then gives `match_offset=16`.
